// File: rtl/sync_ff_filt_if.sv
// Level-signal bundle between an asynchronous source and the synchroniser.
// The master drives d. The slave (the synchroniser) returns the filtered level and edge pulses.
interface sync_ff_filt_if #(
    parameter int unsigned W = 1
);
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;

    modport master (output d, input q, rise, fall, chg);
    modport slave  (input d, output q, rise, fall, chg);
endinterface

// File: rtl/sync_ff_filt.sv
// Multi-channel N-flop synchroniser with a per-channel stability filter.
// Emits registered single-cycle rise/fall pulses on each accepted level change.
module sync_ff_filt #(
    parameter int unsigned     W       = 1,
    parameter int unsigned     N       = 2,
    parameter int unsigned     FILT    = 0,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    sync_ff_filt_if.slave bus
);
    localparam int unsigned    CW      = (FILT == 0) ? 1 : $clog2(FILT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT);

    if (N < 2) begin : g_bad_n
        $error("sync_ff_filt: N must be at least 2");
    end

    logic [W-1:0]  sync_q [N];
    logic [W-1:0]  s;
    logic [CW-1:0] cnt_q  [W];
    logic [CW-1:0] cnt_d  [W];
    logic [W-1:0]  q_q,    q_d;
    logic [W-1:0]  rise_q, rise_d;
    logic [W-1:0]  fall_q, fall_d;
    logic          chg_q,  chg_d;

    assign s = sync_q[N-1];

    // Filter: q moves only after s has disagreed with it for FILT+1 consecutive cycles.
    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            if (s[i] != q_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    q_d[i]    = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        chg_d = |(rise_d | fall_d);
    end

    // The d -> sync_q[0] path is asynchronous and is constrained as a false path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                sync_q[k] <= RST_VAL;
            end
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
            q_q    <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            sync_q[0] <= bus.d;
            for (int k = 1; k < N; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.chg  = chg_q;
endmodule

// File: tb/tb_sync_ff_filt.sv
// Bench for sync_ff_filt: four configurations driven by directed and random levels.
// Outputs are compared every cycle against a sliding-window model of the filter.
module tb_sync_ff_filt;
    logic       clk = 1'b0;
    logic [3:0] d_v   [4];
    logic       rst_v [4];

    int errs   = 0;
    int checks = 0;

    // Model state per instance: d history (index 0 = newest edge) and expected outputs.
    logic [3:0] hist [4][16];
    logic [3:0] mq   [4];
    logic [3:0] mr   [4];
    logic [3:0] mf   [4];

    always #5 clk = ~clk;

    sync_ff_filt_if #(.W(4)) bus0 ();
    sync_ff_filt_if #(.W(1)) bus1 ();
    sync_ff_filt_if #(.W(1)) bus2 ();
    sync_ff_filt_if #(.W(2)) bus3 ();

    assign bus0.d = d_v[0];
    assign bus1.d = d_v[1][0];
    assign bus2.d = d_v[2][0];
    assign bus3.d = d_v[3][1:0];

    sync_ff_filt #(.W(4), .N(2), .FILT(0), .RST_VAL(4'h0))
        u0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
    sync_ff_filt #(.W(1), .N(2), .FILT(3), .RST_VAL(1'b0))
        u1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));
    sync_ff_filt #(.W(1), .N(3), .FILT(2), .RST_VAL(1'b0))
        u2 (.clk(clk), .rst(rst_v[2]), .bus(bus2));
    sync_ff_filt #(.W(2), .N(2), .FILT(7), .RST_VAL(2'b10))
        u3 (.clk(clk), .rst(rst_v[3]), .bus(bus3));

    function automatic int cfg_n(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic int cfg_f(input int k);
        case (k)
            1:       return 3;
            2:       return 2;
            3:       return 7;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] cfg_mask(input int k);
        case (k)
            0:       return 4'hF;
            3:       return 4'h3;
            default: return 4'h1;
        endcase
    endfunction

    function automatic logic [3:0] cfg_rv(input int k);
        return (k == 3) ? 4'h2 : 4'h0;
    endfunction

    // sel: 0=q 1=rise 2=fall 3=chg
    function automatic logic [3:0] obs(input int k, input int sel);
        logic [3:0] v [4];
        case (k)
            0: begin v[0] = bus0.q; v[1] = bus0.rise; v[2] = bus0.fall; v[3] = {3'b0, bus0.chg}; end
            1: begin v[0] = {3'b0, bus1.q}; v[1] = {3'b0, bus1.rise}; v[2] = {3'b0, bus1.fall}; v[3] = {3'b0, bus1.chg}; end
            2: begin v[0] = {3'b0, bus2.q}; v[1] = {3'b0, bus2.rise}; v[2] = {3'b0, bus2.fall}; v[3] = {3'b0, bus2.chg}; end
            default: begin v[0] = {2'b0, bus3.q}; v[1] = {2'b0, bus3.rise}; v[2] = {2'b0, bus3.fall}; v[3] = {3'b0, bus3.chg}; end
        endcase
        return v[sel];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // q[b] takes s[b] once the last FILT+1 synchronised samples all disagree with q[b];
    // the synchronised sample at an edge is the d sampled N edges earlier.
    task automatic model_step(input int k);
        int         n;
        int         f;
        logic [3:0] wm;
        logic [3:0] upd;
        n  = cfg_n(k);
        f  = cfg_f(k);
        wm = cfg_mask(k);
        if (rst_v[k]) begin
            for (int j = 0; j < 16; j++) hist[k][j] = cfg_rv(k);
            mq[k] = cfg_rv(k);
            mr[k] = 4'h0;
            mf[k] = 4'h0;
        end else begin
            for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = d_v[k] & wm;
            upd = wm;
            for (int j = n; j <= n + f; j++) upd &= hist[k][j] ^ mq[k];
            mr[k] = upd & ~mq[k];
            mf[k] = upd & mq[k];
            mq[k] = mq[k] ^ upd;
        end
    endtask

    int rise_n [4];
    int fall_n [4];
    int chg_n  [4];

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("q%0d", k),    obs(k, 0), mq[k]);
            chk($sformatf("rise%0d", k), obs(k, 1), mr[k]);
            chk($sformatf("fall%0d", k), obs(k, 2), mf[k]);
            chk($sformatf("chg%0d", k),  obs(k, 3), {3'b0, |(mr[k] | mf[k])});
            if (obs(k, 1) != 4'h0) rise_n[k]++;
            if (obs(k, 2) != 4'h0) fall_n[k]++;
            if (obs(k, 3) != 4'h0) chg_n[k]++;
        end
    endtask

    int hold [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            d_v[k]   = cfg_rv(k);
            rst_v[k] = 1'b1;
            hold[k]  = 0;
        end
        for (int c = 0; c < 3; c++) cycle();
        for (int k = 0; k < 4; k++) begin
            rise_n[k] = 0;
            fall_n[k] = 0;
            chg_n[k]  = 0;
        end

        // Directed scenarios: clean step, glitch then step, reset mid-filter, steady reset value.
        for (int c = 0; c < 30; c++) begin
            d_v[0]   = 4'hA;
            rst_v[0] = 1'b0;
            d_v[1]   = (c < 3) ? 4'h1 : (c < 7) ? 4'h0 : (c < 17) ? 4'h1 : 4'h0;
            rst_v[1] = 1'b0;
            d_v[2]   = 4'h1;
            rst_v[2] = (c == 4);
            d_v[3]   = 4'h2;
            rst_v[3] = 1'b0;
            cycle();
        end
        chk("dir0_q",      {28'b0, bus0.q}, 32'hA);
        chk("dir0_rise_n", 32'(rise_n[0]), 32'd1);
        chk("dir0_fall_n", 32'(fall_n[0]), 32'd0);
        chk("dir0_chg_n",  32'(chg_n[0]),  32'd1);
        chk("dir1_rise_n", 32'(rise_n[1]), 32'd1);
        chk("dir1_fall_n", 32'(fall_n[1]), 32'd1);
        chk("dir2_q",      {31'b0, bus2.q}, 32'd1);
        chk("dir2_rise_n", 32'(rise_n[2]), 32'd1);
        chk("dir3_q",      {30'b0, bus3.q}, 32'h2);
        chk("dir3_chg_n",  32'(chg_n[3]),  32'd0);

        // Random levels with random hold lengths to mix glitches and stable steps.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (hold[k] == 0) begin
                    d_v[k]  = 4'($urandom) & cfg_mask(k);
                    hold[k] = $urandom_range(1, 14);
                end else begin
                    hold[k]--;
                end
                rst_v[k] = ($urandom_range(0, 99) == 0);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
